// File: rtl/regfile_ctrl_pkg.sv
// Shared definitions for the register-file write-back arbiter:
// controller states, default widths and the two-way grant helper.
package regfile_ctrl_pkg;

  localparam int DEF_REG_DATA_WIDTH = 32;
  localparam int DEF_REG_SEL_BITS   = 5;

  // CLEAR is only reachable when the power-up sweep is compiled in.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

  // One-hot grant for two requesters. req[0]/gnt[0] is A, req[1]/gnt[1] is B.
  // prio_b selects which side wins when both request at once.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic prio_b);
    logic [1:0] gnt;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio_b ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
    return gnt;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. Grants are combinational from the requests
// and the priority flop; priority flips to the loser after every grant
// that is qualified by 'advance'.
module rr_arbiter2
  import regfile_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic prio_q;  // 0: A wins a tie, 1: B wins a tie
  logic prio_d;
  logic [1:0] gnt_s;

  // Grant selection and next priority: the side just served drops to low priority.
  always_comb begin
    gnt_s  = rr_pick(req, prio_q);
    prio_d = prio_q;
    if (advance && (gnt_s != 2'b00)) begin
      prio_d = gnt_s[0];
    end else begin
      prio_d = prio_q;
    end
  end

  // Priority register; reset hands priority to A.
  always_ff @(posedge clock) begin
    if (!reset) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

  assign gnt = gnt_s;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: merges the ALU (A) and load (B) write
// requests onto the single register-file write port with a registered,
// one-cycle-latency output. Writes to select 0 are accepted and dropped.
// Optional macro REGFILE_CLEAR_EN: compiles in a power-up sweep that writes
// zero to selects 1..2^REG_SEL_BITS-1 before requests are serviced.
module regfile_wb_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int REG_DATA_WIDTH = DEF_REG_DATA_WIDTH,
  parameter int REG_SEL_BITS   = DEF_REG_SEL_BITS
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      a_valid,
  input  logic [REG_SEL_BITS-1:0]   a_sel,
  input  logic [REG_DATA_WIDTH-1:0] a_data,
  output logic                      a_ready,
  input  logic                      b_valid,
  input  logic [REG_SEL_BITS-1:0]   b_sel,
  input  logic [REG_DATA_WIDTH-1:0] b_data,
  output logic                      b_ready,
  output logic                      rf_wEn,
  output logic [REG_SEL_BITS-1:0]   rf_write_sel,
  output logic [REG_DATA_WIDTH-1:0] rf_write_data,
  output logic                      init_done
);

  localparam logic [REG_SEL_BITS-1:0]   SEL_ZERO  = {REG_SEL_BITS{1'b0}};
  localparam logic [REG_DATA_WIDTH-1:0] DATA_ZERO = {REG_DATA_WIDTH{1'b0}};

  rf_state_e state_q, state_d;
  logic      run_s;
  logic      clear_s;
  logic [1:0] req_s;
  logic [1:0] gnt_s;
  logic      xfer_s;

  logic                      rf_wen_q, rf_wen_d;
  logic [REG_SEL_BITS-1:0]   rf_sel_q, rf_sel_d;
  logic [REG_DATA_WIDTH-1:0] rf_data_q, rf_data_d;

`ifdef REGFILE_CLEAR_EN
  localparam logic [REG_SEL_BITS-1:0] SEL_ONE  = {{(REG_SEL_BITS-1){1'b0}}, 1'b1};
  localparam logic [REG_SEL_BITS-1:0] SEL_LAST = {REG_SEL_BITS{1'b1}};
  localparam rf_state_e RESET_STATE = CLEAR;

  logic [REG_SEL_BITS-1:0] cnt_q, cnt_d;

  assign clear_s = (state_q == CLEAR);

  // Sweep sequencing: step the select each cycle, leave CLEAR after the last one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + SEL_ONE;
        if (cnt_q == SEL_LAST) begin
          state_d = RUN;
        end else begin
          state_d = CLEAR;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  // Sweep counter; restarts at select 1 whenever reset is applied.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= SEL_ONE;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  localparam rf_state_e RESET_STATE = RUN;

  assign clear_s = 1'b0;

  // Without the sweep the controller lives in RUN permanently.
  always_comb begin
    state_d = RUN;
  end
`endif

  // Requests are only visible to the arbiter while running and out of reset.
  assign run_s  = (state_q == RUN) && reset;
  assign req_s  = {b_valid, a_valid} & {2{run_s}};
  assign xfer_s = |gnt_s;

  rr_arbiter2 u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (req_s),
    .advance (xfer_s),
    .gnt     (gnt_s)
  );

  // Next write-port contents: sweep write, granted request, or idle.
  always_comb begin
    rf_wen_d  = 1'b0;
    rf_sel_d  = SEL_ZERO;
    rf_data_d = DATA_ZERO;
`ifdef REGFILE_CLEAR_EN
    if (clear_s) begin
      rf_wen_d  = 1'b1;
      rf_sel_d  = cnt_q;
      rf_data_d = DATA_ZERO;
    end else
`endif
    if (gnt_s[0]) begin
      rf_wen_d  = (a_sel != SEL_ZERO);
      rf_sel_d  = a_sel;
      rf_data_d = a_data;
    end else if (gnt_s[1]) begin
      rf_wen_d  = (b_sel != SEL_ZERO);
      rf_sel_d  = b_sel;
      rf_data_d = b_data;
    end else begin
      rf_wen_d  = 1'b0;
      rf_sel_d  = SEL_ZERO;
      rf_data_d = DATA_ZERO;
    end
  end

  // State and output registers; reset drops any in-flight write.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= RESET_STATE;
      rf_wen_q  <= 1'b0;
      rf_sel_q  <= SEL_ZERO;
      rf_data_q <= DATA_ZERO;
    end else begin
      state_q   <= state_d;
      rf_wen_q  <= rf_wen_d;
      rf_sel_q  <= rf_sel_d;
      rf_data_q <= rf_data_d;
    end
  end

  assign a_ready       = gnt_s[0];
  assign b_ready       = gnt_s[1];
  assign init_done     = run_s;
  assign rf_wEn        = rf_wen_q;
  assign rf_write_sel  = rf_sel_q;
  assign rf_write_data = rf_data_q;

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter REG_DATA_WIDTH, default 32, the register data width.
REQ-002 SHALL have parameter REG_SEL_BITS, default 5, the register select width; depth is 2^REG_SEL_BITS.
REQ-003 SHALL have port clock  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  the synchronous, active-low reset; 0 = reset, sampled on the clock.
REQ-005 SHALL have ports a_valid in 1, a_sel in REG_SEL_BITS, a_data in REG_DATA_WIDTH: requester A (ALU) write request.
REQ-006 SHALL have port a_ready  out  1  requester A accepted this cycle.
REQ-007 SHALL have ports b_valid in 1, b_sel in REG_SEL_BITS, b_data in REG_DATA_WIDTH: requester B (load) write request.
REQ-008 SHALL have port b_ready  out  1  requester B accepted this cycle.
REQ-009 SHALL have ports rf_wEn out 1, rf_write_sel out REG_SEL_BITS, rf_write_data out REG_DATA_WIDTH: registered drive of the register file write port.
REQ-010 SHALL have port init_done  out  1  register file clear complete; requests now serviced.

Function
REQ-011 SHALL implement states CLEAR and RUN; CLEAR exists only when REGFILE_CLEAR_EN is defined.
REQ-012 SHALL, in CLEAR, issue one write per cycle of data 0 to selects 1 through 2^REG_SEL_BITS-1 in ascending order, then enter RUN.
REQ-013 SHALL hold a_ready=0 and b_ready=0 in CLEAR; init_done SHALL be 0 in CLEAR and 1 in RUN.
REQ-014 SHALL, in RUN, set a request's ready only when that request wins arbitration; ready is combinational from the valids and the priority state.
REQ-015 SHALL accept at most one request per cycle; a transfer occurs when valid and ready are both 1.
REQ-016 SHALL use two-way round-robin: after reset A has priority; after any accepted transfer, priority passes to the other requester.
REQ-017 SHALL grant a lone valid requester regardless of priority.
REQ-018 SHALL present an accepted transfer on rf_wEn/rf_write_sel/rf_write_data one cycle after acceptance, with a latency of exactly 1.
REQ-019 SHALL accept a request with sel 0 but hold rf_wEn at 0 for it, so the write is dropped.
REQ-020 SHALL drive rf_wEn=0 in any RUN cycle following a cycle with no transfer; rf_write_sel and rf_write_data are don't-care when rf_wEn=0.
REQ-021 SHALL give no ordering guarantee between A and B writes to the same select beyond grant order; the later grant wins.
REQ-022 SHALL require requesters to hold valid, sel and data stable until ready; the block does not buffer unaccepted requests.

Reset
REQ-023 SHALL, while reset=0, drive rf_wEn=0, rf_write_sel=0, rf_write_data=0, a_ready=0, b_ready=0, init_done=0, and set priority to A.
REQ-024 SHALL, on reset release, enter CLEAR with the sweep counter at 1 when REGFILE_CLEAR_EN is defined, else enter RUN.
REQ-025 SHALL abort the sweep and restart it at select 1 after the release if reset is asserted mid-CLEAR.
REQ-026 SHALL discard any in-flight output write if reset is asserted mid-RUN; rf_wEn is 0 on the next cycle.

Configuration
REQ-027 SHALL use macro REGFILE_CLEAR_EN: when defined, the CLEAR sweep and its counter are compiled in; when undefined, the block enters RUN directly after reset, init_done=1 from the first post-reset cycle, and no sweep logic exists.

Structure
REQ-028 SHALL place the state enum (CLEAR, RUN) and the default width constants in shared package regfile_ctrl_pkg.
REQ-029 SHALL implement arbitration in sub-module rr_arbiter2 (two requests, two one-hot grants, advance input); the counter and output register stay in the top level.

Verification
REQ-030 SHALL verify the clear sweep (CLEAR_EN, widths 32/5): release reset -> rf_wEn=1 for 31 consecutive cycles with sel 1..31 and data 0, then init_done=1 and rf_wEn=0.
REQ-031 SHALL verify contention: in RUN, hold a_valid=b_valid=1 (a_sel=3, a_data=0xA; b_sel=4, b_data=0xB) for 4 cycles -> grants alternate A,B,A,B and rf writes appear one cycle later.
REQ-032 SHALL verify a lone requester: b_valid=1, sel=7, data=0x1234, a_valid=0 -> b_ready=1 the same cycle, and next cycle rf_wEn=1, sel=7, data=0x1234.
REQ-033 SHALL verify the zero select: a_valid=1, a_sel=0, data=0xFFFF -> a_ready=1, and next cycle rf_wEn=0.
REQ-034 SHALL verify mid-CLEAR reset: assert reset at sweep sel=10 for 1 cycle -> after release the sweep restarts at sel 1 and completes 31 writes.
REQ-035 SHALL verify CLEAR_EN undefined: release reset -> init_done=1 in the first cycle, and a request is granted immediately.
